// File: rtl/gsensor_pkg.sv
// Shared definitions for the G-sensor SPI responder: register map, FSM states, write mask.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package gsensor_pkg;

   // Register addresses (6-bit register space)
   localparam logic [5:0] ADDR_DEVID       = 6'h00;
   localparam logic [5:0] ADDR_BW_RATE     = 6'h2C;
   localparam logic [5:0] ADDR_POWER_CTL   = 6'h2D;
   localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
   localparam logic [5:0] ADDR_DATAX0      = 6'h32;
   localparam logic [5:0] ADDR_DATAX1      = 6'h33;
   localparam logic [5:0] ADDR_DATAY0      = 6'h34;
   localparam logic [5:0] ADDR_DATAY1      = 6'h35;
   localparam logic [5:0] ADDR_DATAZ0      = 6'h36;
   localparam logic [5:0] ADDR_DATAZ1      = 6'h37;

   // Reset value of BW_RATE; every other writable register resets to zero.
   localparam logic [7:0] BW_RATE_RST = 8'h0A;

   // One bit per address, set where the register is writable:
   // 0x1E-0x2A, 0x2C-0x2F, 0x31 and 0x38.
   localparam logic [63:0] WR_MASK = 64'h0102_F7FF_C000_0000;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CMD,
      ST_READ,
      ST_WRITE
   } spi_state_t;

   function automatic logic is_writable(input logic [5:0] a);
      return WR_MASK[a];
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for one asynchronous SPI line plus rise/fall pulse detection.
// Latency: STAGES cycles to q; rise/fall pulse in the same cycle q changes. Backpressure: none.
// Ports: clk/rst (sync, active-high), din (async in), q (synchronized level), rise/fall (1-cycle pulses).
module spi_sync_edge #(
   parameter int   STAGES = 2,
   parameter logic INIT   = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] chain;
   logic              prev;
   // Edges are suppressed until the chain and prev hold real samples again
   // after reset, so a line held low through reset never looks like a new edge.
   logic [STAGES:0]   fill;

   always_ff @(posedge clk) begin
      if (rst) begin
         chain <= {STAGES{INIT}};
         prev  <= INIT;
         fill  <= '0;
      end else begin
         chain[0] <= din;
         for (int i = 1; i < STAGES; i++) begin
            chain[i] <= chain[i-1];
         end
         prev <= chain[STAGES-1];
         fill <= {fill[STAGES-1:0], 1'b1};
      end
   end

   assign q    = chain[STAGES-1];
   assign rise = fill[STAGES] &  q & ~prev;
   assign fall = fill[STAGES] & ~q &  prev;

endmodule

// File: rtl/gsensor_spi_responder.sv
// SPI mode-3 responder emulating an accelerometer register file (reads, writes, burst, data snapshot).
// Latency: SDO updates 1 cycle after a synchronized SCLK fall; writes commit 1 cycle after the 8th sample.
// Backpressure: none; the SPI master paces everything (SCLK at most iCLK/8).
// Ports: iCLK/iRST, SPI pins (iSPI_CSN, iSPI_CLK, iSPI_SDI, oSPI_SDO, oSDO_OE), iACC_X/Y/Z samples,
//        write report (oREG_WR pulse, oREG_ADDR, oREG_WDATA), oBUSY.
module gsensor_spi_responder
   import gsensor_pkg::*;
#(
   parameter logic [7:0] DEVID       = 8'hE5,
   parameter int         SYNC_STAGES = 2
) (
   input  logic        iCLK,
   input  logic        iRST,
   input  logic        iSPI_CSN,
   input  logic        iSPI_CLK,
   input  logic        iSPI_SDI,
   output logic        oSPI_SDO,
   output logic        oSDO_OE,
   input  logic [15:0] iACC_X,
   input  logic [15:0] iACC_Y,
   input  logic [15:0] iACC_Z,
   output logic        oREG_WR,
   output logic [5:0]  oREG_ADDR,
   output logic [7:0]  oREG_WDATA,
   output logic        oBUSY
);

   logic csn_s, csn_rise, csn_fall;
   logic sclk_s, sclk_rise, sclk_fall;
   logic sdi_s, sdi_rise, sdi_fall;

   spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_sync_csn (
      .clk(iCLK), .rst(iRST), .din(iSPI_CSN), .q(csn_s), .rise(csn_rise), .fall(csn_fall)
   );
   spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_sync_sclk (
      .clk(iCLK), .rst(iRST), .din(iSPI_CLK), .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
   );
   spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sync_sdi (
      .clk(iCLK), .rst(iRST), .din(iSPI_SDI), .q(sdi_s), .rise(sdi_rise), .fall(sdi_fall)
   );

   // Only the SDI level is needed; its edges and the CSN/SCLK levels are spare.
   logic unused_sync;
   assign unused_sync = ^{csn_s, sclk_s, sdi_rise, sdi_fall};

   spi_state_t  state;
   logic [2:0]  bit_cnt;
   logic [6:0]  rx_shift;   // first 7 bits of the byte; the 8th comes straight from sdi_s
   logic [7:0]  tx_shift;
   logic [5:0]  addr;
   logic        mb;
   logic [47:0] snap;       // {Z, Y, X}, captured at CSN fall
   logic [7:0]  regs [64];  // only writable addresses are ever loaded

   logic [7:0] rx_byte;
   logic [5:0] addr_next;

   assign rx_byte   = {rx_shift, sdi_s};
   assign addr_next = mb ? addr + 6'd1 : addr;

   function automatic logic [7:0] read_reg(input logic [5:0] a);
      logic [7:0] v;
      v = 8'h00;
      case (a)
         ADDR_DEVID:  v = DEVID;
         ADDR_DATAX0: v = snap[7:0];
         ADDR_DATAX1: v = snap[15:8];
         ADDR_DATAY0: v = snap[23:16];
         ADDR_DATAY1: v = snap[31:24];
         ADDR_DATAZ0: v = snap[39:32];
         ADDR_DATAZ1: v = snap[47:40];
         default:     if (is_writable(a)) v = regs[a];
      endcase
      return v;
   endfunction

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state      <= ST_IDLE;
         bit_cnt    <= '0;
         rx_shift   <= '0;
         tx_shift   <= '0;
         addr       <= '0;
         mb         <= 1'b0;
         snap       <= '0;
         oSPI_SDO   <= 1'b0;
         oSDO_OE    <= 1'b0;
         oREG_WR    <= 1'b0;
         oREG_ADDR  <= '0;
         oREG_WDATA <= '0;
         oBUSY      <= 1'b0;
         for (int i = 0; i < 64; i++) begin
            regs[i] <= (6'(i) == ADDR_BW_RATE) ? BW_RATE_RST : 8'h00;
         end
      end else begin
         oREG_WR <= 1'b0;
         if (csn_rise) begin
            // End of transaction; any partially received byte is simply dropped.
            state    <= ST_IDLE;
            oBUSY    <= 1'b0;
            oSDO_OE  <= 1'b0;
            oSPI_SDO <= 1'b0;
         end else if (csn_fall) begin
            state    <= ST_CMD;
            oBUSY    <= 1'b1;
            bit_cnt  <= '0;
            snap     <= {iACC_Z, iACC_Y, iACC_X};
            oSDO_OE  <= 1'b0;
            oSPI_SDO <= 1'b0;
         end else begin
            case (state)
               ST_CMD: begin
                  if (sclk_rise) begin
                     rx_shift <= {rx_shift[5:0], sdi_s};
                     bit_cnt  <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        // rx_byte = {R/W, MB, addr[5:0]}
                        addr <= rx_byte[5:0];
                        mb   <= rx_byte[6];
                        if (rx_byte[7]) begin
                           state    <= ST_READ;
                           oSDO_OE  <= 1'b1;
                           tx_shift <= read_reg(rx_byte[5:0]);
                        end else begin
                           state <= ST_WRITE;
                        end
                     end
                  end
               end
               ST_READ: begin
                  if (sclk_fall) begin
                     oSPI_SDO <= tx_shift[7];
                     tx_shift <= {tx_shift[6:0], 1'b0};
                  end else if (sclk_rise) begin
                     bit_cnt <= bit_cnt + 3'd1;
                     // Master has taken the last bit: fetch the next byte
                     // ahead of the coming falling edge.
                     if (bit_cnt == 3'd7) begin
                        addr     <= addr_next;
                        tx_shift <= read_reg(addr_next);
                     end
                  end
               end
               ST_WRITE: begin
                  if (sclk_rise) begin
                     rx_shift <= {rx_shift[5:0], sdi_s};
                     bit_cnt  <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        if (is_writable(addr)) begin
                           regs[addr] <= rx_byte;
                           oREG_WR    <= 1'b1;
                           oREG_ADDR  <= addr;
                           oREG_WDATA <= rx_byte;
                        end
                        addr <= addr_next;
                     end
                  end
               end
               default: ; // ST_IDLE: bus activity ignored until CSN falls
            endcase
         end
      end
   end

endmodule

// File: tb/tb_gsensor_spi_responder.sv
// Self-checking bench for gsensor_spi_responder: acts as SPI mode-3 master against a register-map model.
// Latency: n/a. Backpressure: n/a.
// Ports: none (top-level bench).
module tb_gsensor_spi_responder;

   localparam int HALF = 6;  // iCLK cycles per SCLK half-period

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        csn = 1'b1;
   logic        sclk = 1'b1;
   logic        sdi = 1'b0;
   logic [15:0] ax = '0, ay = '0, az = '0;
   logic        sdo, oe, reg_wr, busy;
   logic [5:0]  reg_addr;
   logic [7:0]  reg_wdata;

   always #10 clk = ~clk;

   gsensor_spi_responder dut (
      .iCLK(clk), .iRST(rst),
      .iSPI_CSN(csn), .iSPI_CLK(sclk), .iSPI_SDI(sdi),
      .oSPI_SDO(sdo), .oSDO_OE(oe),
      .iACC_X(ax), .iACC_Y(ay), .iACC_Z(az),
      .oREG_WR(reg_wr), .oREG_ADDR(reg_addr), .oREG_WDATA(reg_wdata),
      .oBUSY(busy)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   logic [7:0] mem [64];
   logic [7:0] snap_m [6];
   logic [7:0] wbuf [16];
   logic [7:0] rbuf [16];
   logic [7:0] exp_rd [16];
   logic [5:0] exp_addr [$];
   logic [7:0] exp_data [$];
   logic [5:0] mon_addr [$];
   logic [7:0] mon_data [$];
   logic       oe_bad, busy_bad, exp_busy;
   int         acc_change_after = -1;

   always @(negedge clk) begin
      if (reg_wr === 1'b1) begin
         mon_addr.push_back(reg_addr);
         mon_data.push_back(reg_wdata);
      end
   end

   function automatic logic model_wr(input int a);
      return (a >= 30 && a <= 42) || (a >= 44 && a <= 47) || a == 49 || a == 56;
   endfunction

   function automatic logic [7:0] model_read(input int a);
      if (a == 0) return 8'hE5;
      if (a >= 50 && a <= 55) return snap_m[a-50];
      if (model_wr(a)) return mem[a];
      return 8'h00;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 64; i++) mem[i] = 8'h00;
      mem[44] = 8'h0A;
      for (int i = 0; i < 6; i++) snap_m[i] = 8'h00;
   endtask

   // Full-byte effect of a transaction; call just before the transaction starts.
   task automatic model_txn(input logic [7:0] cmd, input int nbytes);
      int a;
      a = int'(cmd[5:0]);
      snap_m[0] = ax[7:0]; snap_m[1] = ax[15:8];
      snap_m[2] = ay[7:0]; snap_m[3] = ay[15:8];
      snap_m[4] = az[7:0]; snap_m[5] = az[15:8];
      for (int i = 0; i < nbytes; i++) begin
         if (cmd[7]) begin
            exp_rd[i] = model_read(a);
         end else if (model_wr(a)) begin
            mem[a] = wbuf[i];
            exp_addr.push_back(6'(a));
            exp_data.push_back(wbuf[i]);
         end
         if (cmd[6]) a = (a + 1) % 64;
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bits(input logic [7:0] tx, input int nbits, input logic exp_oe,
                            output logic [7:0] rx);
      int b;
      rx = 8'h00;
      for (int k = 0; k < nbits; k++) begin
         b = 7 - k;
         sclk = 1'b0;
         sdi  = tx[b];
         tick(HALF);
         rx[b] = sdo;
         if (oe !== exp_oe) oe_bad = 1'b1;
         if (busy !== exp_busy) busy_bad = 1'b1;
         sclk = 1'b1;
         tick(HALF);
      end
   endtask

   task automatic spi_txn(input logic [7:0] cmd, input int nbytes, input int tail_bits, input int gap);
      logic [7:0] r;
      oe_bad = 1'b0; busy_bad = 1'b0; exp_busy = 1'b1;
      csn = 1'b0;
      tick(HALF);
      send_bits(cmd, 8, 1'b0, r);
      for (int i = 0; i < nbytes; i++) begin
         send_bits(wbuf[i], 8, cmd[7], r);
         rbuf[i] = r;
         if (i == acc_change_after) begin
            ax = 16'($urandom); ay = 16'($urandom); az = 16'($urandom);
         end
      end
      if (tail_bits > 0) send_bits(wbuf[nbytes], tail_bits, cmd[7], r);
      tick(2);
      csn = 1'b1;
      tick(gap);
   endtask

   task automatic clear_q();
      mon_addr.delete(); mon_data.delete();
      exp_addr.delete(); exp_data.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(4);
      n_cmp += 6;
      if (sdo !== 1'b0)      begin n_bad++; $display("FAIL reset_sdo: got %b want 0", sdo); end
      if (oe !== 1'b0)       begin n_bad++; $display("FAIL reset_oe: got %b want 0", oe); end
      if (reg_wr !== 1'b0)   begin n_bad++; $display("FAIL reset_wr: got %b want 0", reg_wr); end
      if (reg_addr !== 6'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 00", reg_addr); end
      if (reg_wdata !== 8'h0) begin n_bad++; $display("FAIL reset_wdata: got %h want 00", reg_wdata); end
      if (busy !== 1'b0)     begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      rst = 1'b0;
      model_reset();
      tick(4);
   endtask

   task automatic test_devid();
      wbuf[0] = 8'h00;
      spi_txn(8'h80, 1, 0, HALF);
      n_cmp += 4;
      if (rbuf[0] !== 8'hE5) begin n_bad++; $display("FAIL devid: got %h want e5", rbuf[0]); end
      if (oe_bad !== 1'b0)   begin n_bad++; $display("FAIL devid_oe: got bad=%b want 0", oe_bad); end
      if (busy_bad !== 1'b0) begin n_bad++; $display("FAIL devid_busy: got bad=%b want 0", busy_bad); end
      if (oe !== 1'b0 || busy !== 1'b0) begin
         n_bad++; $display("FAIL devid_idle: got oe=%b busy=%b want 0 0", oe, busy);
      end
   endtask

   task automatic test_accel_burst();
      logic [7:0] want [6] = '{8'h34, 8'h12, 8'h80, 8'hFF, 8'h00, 8'h01};
      ax = 16'h1234; ay = 16'hFF80; az = 16'h0100;
      for (int i = 0; i < 6; i++) wbuf[i] = 8'h00;
      model_txn(8'hF2, 6);
      acc_change_after = 1;
      spi_txn(8'hF2, 6, 0, HALF);
      acc_change_after = -1;
      for (int i = 0; i < 6; i++) begin
         n_cmp++;
         if (rbuf[i] !== want[i]) begin
            n_bad++; $display("FAIL accel_byte%0d: got %h want %h", i, rbuf[i], want[i]);
         end
      end
   endtask

   task automatic test_write_readback();
      clear_q();
      wbuf[0] = 8'h08;
      model_txn(8'h2D, 1);
      spi_txn(8'h2D, 1, 0, HALF);
      n_cmp++;
      if (mon_addr.size() != 1) begin
         n_bad++; $display("FAIL wr_pulses: got %0d want 1", mon_addr.size());
      end else begin
         n_cmp += 2;
         if (mon_addr[0] !== 6'h2D) begin n_bad++; $display("FAIL wr_addr: got %h want 2d", mon_addr[0]); end
         if (mon_data[0] !== 8'h08) begin n_bad++; $display("FAIL wr_data: got %h want 08", mon_data[0]); end
      end
      wbuf[0] = 8'h00;
      spi_txn(8'hAD, 1, 0, HALF);
      n_cmp++;
      if (rbuf[0] !== 8'h08) begin n_bad++; $display("FAIL rd_2d: got %h want 08", rbuf[0]); end
      spi_txn(8'hAC, 1, 0, HALF);
      n_cmp++;
      if (rbuf[0] !== 8'h0A) begin n_bad++; $display("FAIL rd_bw_rate: got %h want 0a", rbuf[0]); end
   endtask

   task automatic test_ro_write();
      clear_q();
      wbuf[0] = 8'hFF;
      spi_txn(8'h00, 1, 0, HALF);
      wbuf[0] = 8'h00;
      spi_txn(8'h80, 1, 0, HALF);
      n_cmp += 2;
      if (mon_addr.size() != 0) begin n_bad++; $display("FAIL ro_pulses: got %0d want 0", mon_addr.size()); end
      if (rbuf[0] !== 8'hE5)    begin n_bad++; $display("FAIL ro_devid: got %h want e5", rbuf[0]); end
   endtask

   task automatic test_wrap();
      wbuf[0] = 8'h00; wbuf[1] = 8'h00;
      spi_txn(8'hFF, 2, 0, HALF);
      n_cmp += 2;
      if (rbuf[0] !== 8'h00) begin n_bad++; $display("FAIL wrap_3f: got %h want 00", rbuf[0]); end
      if (rbuf[1] !== 8'hE5) begin n_bad++; $display("FAIL wrap_00: got %h want e5", rbuf[1]); end
   endtask

   task automatic test_partial_back_to_back();
      wbuf[0] = 8'h0B;
      model_txn(8'h31, 1);
      spi_txn(8'h31, 1, 0, HALF);
      clear_q();
      wbuf[0] = 8'h55;
      spi_txn(8'h31, 0, 5, 1);        // CSN up mid-byte, down again one cycle later
      wbuf[0] = 8'h00;
      spi_txn(8'hB1, 1, 0, HALF);
      n_cmp += 2;
      if (mon_addr.size() != 0) begin n_bad++; $display("FAIL partial_pulses: got %0d want 0", mon_addr.size()); end
      if (rbuf[0] !== 8'h0B)    begin n_bad++; $display("FAIL partial_31: got %h want 0b", rbuf[0]); end
   endtask

   task automatic test_ignore_idle();
      clear_q();
      oe_bad = 1'b0; busy_bad = 1'b0; exp_busy = 1'b0;
      begin
         logic [7:0] r;
         send_bits(8'($urandom), 8, 1'b0, r);
         send_bits(8'($urandom), 8, 1'b0, r);
      end
      n_cmp += 3;
      if (mon_addr.size() != 0) begin n_bad++; $display("FAIL idle_pulses: got %0d want 0", mon_addr.size()); end
      if (busy_bad !== 1'b0)    begin n_bad++; $display("FAIL idle_busy: got bad=%b want 0", busy_bad); end
      if (oe_bad !== 1'b0)      begin n_bad++; $display("FAIL idle_oe: got bad=%b want 0", oe_bad); end
   endtask

   task automatic test_reset_abort();
      logic [7:0] r;
      clear_q();
      oe_bad = 1'b0; busy_bad = 1'b0; exp_busy = 1'b1;
      csn = 1'b0;
      tick(HALF);
      send_bits(8'h2D, 8, 1'b0, r);
      send_bits(8'hA0, 3, 1'b0, r);
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      model_reset();
      exp_busy = 1'b0;
      send_bits(8'h1F, 5, 1'b0, r);
      send_bits(8'h77, 8, 1'b0, r);
      tick(2);
      csn = 1'b1;
      tick(HALF);
      n_cmp += 2;
      if (mon_addr.size() != 0) begin n_bad++; $display("FAIL abort_pulses: got %0d want 0", mon_addr.size()); end
      if (busy_bad !== 1'b0)    begin n_bad++; $display("FAIL abort_busy: got bad=%b want 0", busy_bad); end
      wbuf[0] = 8'h00;
      spi_txn(8'hAD, 1, 0, HALF);
      n_cmp++;
      if (rbuf[0] !== 8'h00) begin n_bad++; $display("FAIL abort_2d: got %h want 00", rbuf[0]); end
      spi_txn(8'hAC, 1, 0, HALF);
      n_cmp++;
      if (rbuf[0] !== 8'h0A) begin n_bad++; $display("FAIL abort_bw_rate: got %h want 0a", rbuf[0]); end
   endtask

   task automatic test_random();
      logic [7:0] cmd;
      int         nb;
      for (int t = 0; t < 30; t++) begin
         clear_q();
         cmd = 8'($urandom);
         nb  = $urandom_range(1, 4);
         for (int i = 0; i < 5; i++) wbuf[i] = 8'($urandom);
         ax = 16'($urandom); ay = 16'($urandom); az = 16'($urandom);
         model_txn(cmd, nb);
         acc_change_after = $urandom_range(0, 3);
         spi_txn(cmd, nb, 0, $urandom_range(1, 8));
         acc_change_after = -1;
         n_cmp += 2;
         if (oe_bad !== 1'b0) begin n_bad++; $display("FAIL rnd%0d_oe: cmd %h got bad=%b want 0", t, cmd, oe_bad); end
         if (mon_addr.size() != exp_addr.size()) begin
            n_bad++; $display("FAIL rnd%0d_pulses: cmd %h got %0d want %0d", t, cmd, mon_addr.size(), exp_addr.size());
         end else begin
            for (int i = 0; i < exp_addr.size(); i++) begin
               n_cmp++;
               if (mon_addr[i] !== exp_addr[i] || mon_data[i] !== exp_data[i]) begin
                  n_bad++; $display("FAIL rnd%0d_wr%0d: got %h/%h want %h/%h", t, i,
                                    mon_addr[i], mon_data[i], exp_addr[i], exp_data[i]);
               end
            end
         end
         if (cmd[7]) begin
            for (int i = 0; i < nb; i++) begin
               n_cmp++;
               if (rbuf[i] !== exp_rd[i]) begin
                  n_bad++; $display("FAIL rnd%0d_rd%0d: cmd %h got %h want %h", t, i, cmd, rbuf[i], exp_rd[i]);
               end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_devid();
      test_accel_burst();
      test_write_readback();
      test_ro_write();
      test_wrap();
      test_partial_back_to_back();
      test_ignore_idle();
      test_reset_abort();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/gsensor_spi_responder.md
GSENSOR_SPI_RESPONDER -- requirements
Module: gsensor_spi_responder

Interface
REQ-001 SHALL have parameter DEVID, default 8'hE5, the constant returned from register 0x00.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, the synchronizer depth on CSN, SCLK and SDI.
REQ-003 SHALL have port iCLK, input, 1 bit: the single system clock (50 MHz); all logic on its rising edge.
REQ-004 SHALL have port iRST, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port iSPI_CSN, input, 1 bit: SPI chip select, active low.
REQ-006 SHALL have port iSPI_CLK, input, 1 bit: SPI clock, mode 3 (idle high), at most iCLK/8.
REQ-007 SHALL have port iSPI_SDI, input, 1 bit: master-to-responder data.
REQ-008 SHALL have port oSPI_SDO, output, 1 bit: responder-to-master data.
REQ-009 SHALL have port oSDO_OE, output, 1 bit: SDO drive enable.
REQ-010 SHALL have ports iACC_X, iACC_Y and iACC_Z, each input, 16 bits: signed acceleration samples.
REQ-011 SHALL have port oREG_WR, output, 1 bit: one-cycle pulse for each accepted register write.
REQ-012 SHALL have port oREG_ADDR, output, 6 bits: address of the last accepted write.
REQ-013 SHALL have port oREG_WDATA, output, 8 bits: data of the last accepted write.
REQ-014 SHALL have port oBUSY, output, 1 bit: high while a transaction is active (synchronized CSN low).

Function
REQ-015 SHALL sample SDI only on a detected rising edge of the synchronized SCLK.
REQ-016 SHALL update SDO on the iCLK cycle after a detected falling edge of the synchronized SCLK.
REQ-017 SHALL interpret the first byte MSB-first: bit7 = R/W (1 = read), bit6 = MB, bits5:0 = start address.
REQ-018 SHALL implement FSM states IDLE, CMD, READ and WRITE.
REQ-019 SHALL move IDLE->CMD on the CSN falling edge, and CMD->READ or CMD->WRITE after the 8th SDI sample, selected by R/W.
REQ-020 SHALL return to IDLE from any state on the CSN rising edge.
REQ-021 SHALL, on the CSN falling edge, snapshot iACC_X/Y/Z into registers 0x32..0x37 (little-endian: 0x32 = X[7:0], 0x33 = X[15:8]); the snapshot SHALL stay stable until the next CSN falling edge.
REQ-022 In READ, SHALL drive the data byte MSB-first, bit7 presented on the first SCLK falling edge after the command byte; oSDO_OE high for the whole READ phase, low otherwise, with oSPI_SDO = 0 when not enabled.
REQ-023 In WRITE, SHALL commit each complete received byte, on the iCLK cycle after its 8th sample, to the addressed register if writable, and pulse oREG_WR with the address and data.
REQ-024 SHALL silently ignore writes to read-only addresses, with no oREG_WR pulse.
REQ-025 Writable addresses SHALL be 0x1E-0x2A, 0x2C-0x2F, 0x31 and 0x38; all others are read-only.
REQ-026 Read-only addresses other than 0x00 and 0x32-0x37 SHALL read 8'h00.
REQ-027 If MB = 1, SHALL post-increment the address after each byte, wrapping 0x3F->0x00; if MB = 0, SHALL repeat the same address for every subsequent byte.
REQ-028 SHALL discard a partial byte when CSN rises mid-byte: no write, no pulse, no register change.
REQ-029 SHALL restart cleanly in CMD when a new CSN falling edge arrives one iCLK cycle after the previous rise.
REQ-030 SHALL ignore SCLK and SDI activity while CSN is high.

Reset
REQ-031 On iRST, SHALL force: FSM = IDLE, oSPI_SDO = 0, oSDO_OE = 0, oREG_WR = 0, oREG_ADDR = 0, oREG_WDATA = 0, oBUSY = 0, bit counter = 0.
REQ-032 On iRST, SHALL clear writable registers to 0 except 0x2C = 8'h0A, and clear the data snapshot to 0.
REQ-033 iRST asserted mid-transaction SHALL abort it; after release the block SHALL ignore the bus until the next CSN falling edge.

Structure
REQ-034 Package gsensor_pkg SHALL hold the register address constants (DEVID, BW_RATE, POWER_CTL, DATA_FORMAT, DATAX0..DATAZ1), the FSM state typedef and the writable-address mask.
REQ-035 Sub-module spi_sync_edge SHALL implement the SYNC_STAGES synchronizer plus rise/fall pulse detection; it SHALL be instantiated once per CSN, SCLK and SDI.

Verification
REQ-036 Single read of 0x00 (cmd 8'h80) SHALL return 8'hE5 on SDO, with oSDO_OE high only during the data byte.
REQ-037 With iACC_X/Y/Z = 16'h1234/16'hFF80/16'h0100, a multi-byte read at 0x32 (cmd 8'hF2) over 6 bytes SHALL return 34 12 80 FF 00 01, even when the inputs change mid-burst.
REQ-038 Write 8'h08 to 0x2D (cmd 8'h2D) then reading back 0x2D SHALL give one oREG_WR pulse with ADDR = 0x2D and WDATA = 8'h08, and read back 8'h08.
REQ-039 Write 8'hFF to 0x00 SHALL produce no oREG_WR pulse, and 0x00 SHALL still read 8'hE5.
REQ-040 Multi-byte read from 0x3F over 2 bytes SHALL return reg 0x3F then reg 0x00 (8'h00, 8'hE5).
REQ-041 Raising CSN after 5 bits of a write data byte to 0x31 SHALL leave 0x31 unchanged with no pulse, and a back-to-back new transaction SHALL decode correctly.
